// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// scan_chain_ctrl : load / capture / unload sequencer for one scan chain with
//                   expected-response compare, sticky fail and pattern count.
// Optional MISR response signature enabled by macro SCAN_MISR_EN.
// Revision: 1.0
// ============================================================================
module scan_chain_ctrl #(
  parameter int                   CHAIN_LEN = 8,
  parameter int                   CNT_W     = 4,
  parameter logic [CHAIN_LEN-1:0] MISR_POLY = 8'hB8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic [CHAIN_LEN-1:0] exp_data,
  input  logic                 pat_last,
  output logic                 scan_se,
  output logic                 scan_si,
  input  logic                 scan_so,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [7:0]           pat_count,
  output logic [CHAIN_LEN-1:0] resp_data,
  output logic [CHAIN_LEN-1:0] misr_sig
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_UNLOAD  = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic [2:0]           r_state;
  logic [CHAIN_LEN-1:0] r_pat_sr;
  logic [CHAIN_LEN-1:0] r_resp_sr;
  logic [CHAIN_LEN-1:0] r_exp_cur;
  logic [CHAIN_LEN-1:0] r_exp_prev;
  logic                 r_have_prev;
  logic                 r_last;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_fail;
  logic                 r_done;
  logic [7:0]           r_pat_count;
  logic [CHAIN_LEN-1:0] r_resp_data;

  logic w_start;
  logic w_cmp;

  assign w_start = (r_state == S_IDLE) && start;
  // The response sitting in resp_sr belongs to the previous pattern, so a
  // compare happens at every capture except the first of a session.
  assign w_cmp   = ((r_state == S_CAPTURE) && r_have_prev) || (r_state == S_CHECK);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pat_sr    <= '0;
      r_resp_sr   <= '0;
      r_exp_cur   <= '0;
      r_exp_prev  <= '0;
      r_have_prev <= 1'b0;
      r_last      <= 1'b0;
      r_cnt       <= '0;
      r_fail      <= 1'b0;
      r_done      <= 1'b0;
      r_pat_count <= 8'd0;
      r_resp_data <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_cmp) begin
        r_resp_data <= r_resp_sr;
        r_fail      <= r_fail | (r_resp_sr != r_exp_prev);
      end
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state     <= S_WAIT;
            r_fail      <= 1'b0;
            r_pat_count <= 8'd0;
            r_have_prev <= 1'b0;
          end
        end
        S_WAIT: begin
          if (pat_valid) begin
            r_pat_sr  <= pat_data;
            r_exp_cur <= exp_data;
            r_last    <= pat_last;
            r_cnt     <= '0;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_pat_sr  <= r_pat_sr << 1;
          r_resp_sr <= {r_resp_sr[CHAIN_LEN-2:0], scan_so};
          r_cnt     <= r_cnt + c_CNT_ONE;
          if (r_cnt == c_CNT_LAST) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_exp_prev  <= r_exp_cur;
          r_have_prev <= 1'b1;
          if (r_pat_count != 8'hFF) r_pat_count <= r_pat_count + 8'd1;
          r_cnt       <= '0;
          r_state     <= r_last ? S_UNLOAD : S_WAIT;
        end
        S_UNLOAD: begin
          r_resp_sr <= {r_resp_sr[CHAIN_LEN-2:0], scan_so};
          r_cnt     <= r_cnt + c_CNT_ONE;
          if (r_cnt == c_CNT_LAST) r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SCAN_MISR_EN
  logic [CHAIN_LEN-1:0] r_misr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_misr <= '0;
    end else if (w_start) begin
      r_misr <= '0;
    end else if (w_cmp) begin
      r_misr <= (r_misr >> 1) ^ (r_misr[0] ? MISR_POLY : '0) ^ r_resp_sr;
    end
  end

  assign misr_sig = r_misr;
`else
  logic w_unused_poly;
  assign w_unused_poly = ^MISR_POLY;
  assign misr_sig      = '0;
`endif

  assign pat_ready = (r_state == S_WAIT);
  assign scan_se   = (r_state == S_SHIFT) || (r_state == S_UNLOAD);
  assign scan_si   = (r_state == S_SHIFT) && r_pat_sr[CHAIN_LEN-1];
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign fail      = r_fail;
  assign pat_count = r_pat_count;
  assign resp_data = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// tb_scan_chain_ctrl : bench for scan_chain_ctrl with an 8-cell chain whose
//                      functional input is the inverse of each cell.
// Revision: 1.0
// ============================================================================
module tb_scan_chain_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         pat_valid = 1'b0;
  logic         pat_last = 1'b0;
  logic [N-1:0] pat_data = '0;
  logic [N-1:0] exp_data = '0;
  logic         scan_so;
  logic         pat_ready, scan_se, scan_si, busy, done, fail;
  logic [7:0]   pat_count;
  logic [N-1:0] resp_data, misr_sig;

  scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(4), .MISR_POLY(8'hB8)) dut (
    .clk(clk), .reset(reset), .start(start), .pat_valid(pat_valid),
    .pat_ready(pat_ready), .pat_data(pat_data), .exp_data(exp_data),
    .pat_last(pat_last), .scan_se(scan_se), .scan_si(scan_si),
    .scan_so(scan_so), .busy(busy), .done(done), .fail(fail),
    .pat_count(pat_count), .resp_data(resp_data), .misr_sig(misr_sig)
  );

  always #5 clk = ~clk;

  // Chain of scan cells; the functional clock pulse only follows a scan burst.
  logic [N-1:0] chain = '0;
  logic         prev_se = 1'b0;
  assign scan_so = chain[N-1];
  always @(posedge clk) begin
    if (scan_se)      chain <= {chain[N-2:0], scan_si};
    else if (prev_se) chain <= ~chain;
    prev_se <= scan_se;
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Transaction-level model: a timeline of expected outputs per cycle.
  typedef struct {
    logic         ready, se, si, busy, done, fail;
    logic [7:0]   cnt;
    logic [N-1:0] resp, misr;
  } exp_t;

  exp_t         cur;
  exp_t         tl[$];
  bit           m_on = 0;
  bit           sess = 0;
  bit           have_prev = 0;
  logic [N-1:0] prev_resp = '0, exp_prev = '0, m_resp = '0, m_misr = '0;
  logic         m_fail = 0;
  int           m_cnt = 0;

  function automatic exp_t mk(input logic rdy, input logic se, input logic si,
                              input logic bz, input logic dn);
    exp_t x;
    x.ready = rdy; x.se = se; x.si = si; x.busy = bz; x.done = dn;
    x.fail = m_fail; x.cnt = 8'(m_cnt); x.resp = m_resp; x.misr = m_misr;
    return x;
  endfunction

  function automatic void cmp_event(input logic [N-1:0] r);
    m_resp = r;
    if (r != exp_prev) m_fail = 1'b1;
`ifdef SCAN_MISR_EN
    m_misr = (m_misr >> 1) ^ (m_misr[0] ? 8'hB8 : 8'h00) ^ r;
`endif
  endfunction

  function automatic void accept(input logic [N-1:0] p, input logic [N-1:0] e, input logic l);
    for (int k = 0; k < N; k++) tl.push_back(mk(0, 1, p[N-1-k], 1, 0));
    tl.push_back(mk(0, 0, 0, 1, 0));
    if (have_prev) cmp_event(prev_resp);
    prev_resp = ~p;
    exp_prev  = e;
    have_prev = 1;
    if (m_cnt < 255) m_cnt++;
    if (l) begin
      for (int k = 0; k < N; k++) tl.push_back(mk(0, 1, 0, 1, 0));
      tl.push_back(mk(0, 0, 0, 1, 0));
      cmp_event(prev_resp);
      sess = 0;
      tl.push_back(mk(0, 0, 0, 0, 1));
    end
    cur = tl.pop_front();
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_on = 1; sess = 0; have_prev = 0; m_fail = 0; m_cnt = 0;
      m_resp = '0; m_misr = '0; exp_prev = '0; prev_resp = '0;
      tl.delete();
      cur = mk(0, 0, 0, 0, 0);
    end else if (tl.size() > 0) begin
      cur = tl.pop_front();
    end else if (!sess) begin
      if (start) begin
        sess = 1; m_fail = 0; m_cnt = 0; have_prev = 0; m_misr = '0;
        cur = mk(1, 0, 0, 1, 0);
      end else begin
        cur = mk(0, 0, 0, 0, 0);
      end
    end else if (cur.ready && pat_valid) begin
      accept(pat_data, exp_data, pat_last);
    end else begin
      cur = mk(1, 0, 0, 1, 0);
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("pat_ready", pat_ready, cur.ready);
      chk("scan_se",   scan_se,   cur.se);
      chk("scan_si",   scan_si,   cur.si);
      chk("busy",      busy,      cur.busy);
      chk("done",      done,      cur.done);
      chk("fail",      fail,      cur.fail);
      chk("pat_count", pat_count, cur.cnt);
      chk("resp_data", resp_data, cur.resp);
      chk("misr_sig",  misr_sig,  cur.misr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] p, input logic [N-1:0] e, input logic l,
                      input int gap, output int acc, output int tries);
    logic r;
    pat_valid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
    pat_data = p; exp_data = e; pat_last = l; pat_valid = 1'b1;
    acc = -1; tries = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      r = pat_ready;
      tick();
      tries++;
      if (r) begin
        acc = cyc;
        break;
      end
    end
    pat_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int acc, output int lat, output logic [63:0] sev);
    bit got;
    got = 0; sev = '0; lat = -1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        lat = cyc - acc;
      end else begin
        sev = {sev[62:0], scan_se};
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, tries, lat;
    logic [63:0] sev;
    logic [N-1:0] p, e;
    int np;

    tick(); tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_count", pat_count, 0);
    tick();

    // Single pattern
    do_start();
    send(8'hA5, 8'h5A, 1, 0, acc, tries);
    wait_done(acc, lat, sev);
    chk("single_latency", lat, 18);
    chk("single_se_seq", sev[17:0], 18'b111111110111111110);
    chk("single_resp", resp_data, 8'h5A);
    chk("single_fail", fail, 0);
    chk("single_count", pat_count, 1);
    chk("model_resp_pin", m_resp, 8'h5A);

    // Mismatch, sticky until next start
    do_start();
    send(8'hA5, 8'h00, 1, 0, acc, tries);
    wait_done(acc, lat, sev);
    chk("mismatch_fail", fail, 1);
    chk("model_fail_pin", m_fail, 1);
    tick(); tick(); tick();
    @(negedge clk);
    chk("mismatch_sticky", fail, 1);
    tick();
    do_start();
    @(negedge clk);
    chk("start_clears_fail", fail, 0);
    tick();

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", pat_ready, 1);
      chk("bp_se", scan_se, 0);
      tick();
    end
    send(8'hA5, 8'h5A, 1, 0, acc, tries);
    chk("bp_first_accept", tries, 1);
    wait_done(acc, lat, sev);
    chk("bp_resp", resp_data, 8'h5A);

    // Reset in the middle of SHIFT
    do_start();
    send(8'hA5, 8'h5A, 1, 0, acc, tries);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_se", scan_se, 0);
    chk("rst_count", pat_count, 0);
    chk("rst_fail", fail, 0);
    tick();
    reset = 1'b0;
    tick();
    do_start();
    send(8'h96, 8'h69, 1, 0, acc, tries);
    wait_done(acc, lat, sev);
    chk("post_rst_latency", lat, 18);
    chk("post_rst_resp", resp_data, 8'h69);
    chk("post_rst_fail", fail, 0);

    // Back-to-back patterns
    do_start();
    send(8'h0F, 8'hF0, 0, 0, acc, tries);
    send(8'h3C, 8'hC3, 1, 0, acc, tries);
    wait_done(acc, lat, sev);
    chk("b2b_fail", fail, 0);
    chk("b2b_count", pat_count, 2);
    chk("b2b_resp", resp_data, 8'hC3);
`ifdef SCAN_MISR_EN
    chk("b2b_misr", misr_sig, 8'hBB);
    chk("model_misr_pin", m_misr, 8'hBB);
`else
    chk("b2b_misr", misr_sig, 8'h00);
`endif

    // Randomized sessions, with stray start pulses while busy
    for (int s = 0; s < 25; s++) begin
      do_start();
      np = $urandom_range(1, 4);
      for (int k = 0; k < np; k++) begin
        p = N'($urandom);
        e = ($urandom_range(0, 3) == 0) ? N'($urandom) : ~p;
        for (int g = $urandom_range(0, 3); g > 0; g--) begin
          start = ($urandom_range(0, 3) == 0);
          tick();
          start = 1'b0;
        end
        send(p, e, (k == np - 1), 0, acc, tries);
      end
      wait_done(acc, lat, sev);
      chk("rand_latency", lat, 18);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    // Pattern count saturation
    do_start();
    for (int k = 0; k < 260; k++) begin
      p = N'($urandom);
      send(p, ~p, (k == 259), 0, acc, tries);
    end
    wait_done(acc, lat, sev);
    chk("sat_count", pat_count, 255);
    chk("sat_fail", fail, 0);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
